// File: rtl/align_pkg.sv
// Shared widths, types and shift-distance helper for the BFP alignment stage.
// Optional sticky-bit jamming is enabled with the ALIGN_STICKY_EN macro.
package align_pkg;

  localparam int EXP_W = 5;
  localparam int PP_W  = 5;
  localparam int OUT_W = 16;
  localparam int G     = OUT_W - PP_W;
  // Enough bits to encode a shift of exactly OUT_W (full saturation).
  localparam int SH_W  = $clog2(OUT_W + 1);

  typedef logic [EXP_W-1:0]       exp_t;
  typedef logic signed [PP_W-1:0] pp_t;
  typedef logic [OUT_W-1:0]       aligned_t;

  // Clamp the distance so that anything at or beyond OUT_W shifts out every bit.
  function automatic logic [SH_W-1:0] sat_shift(input exp_t d);
    if (32'(d) >= OUT_W) return SH_W'(OUT_W);
    return SH_W'(d);
  endfunction

endpackage

// File: rtl/align_barrel_shifter.sv
// Combinational log-barrel arithmetic right shifter (stages 1/2/4/8/16).
// With ALIGN_STICKY_EN defined it also reports the OR of all bits shifted out.
module align_barrel_shifter
  import align_pkg::*;
(
  input  aligned_t data_i,
  input  exp_t     dist_i,
  output aligned_t data_o,
  output logic     sat_o,
  output logic     sticky_o
);

  logic [SH_W-1:0] amt;
  aligned_t        stage [SH_W+1];

  assign amt      = sat_shift(dist_i);
  assign sat_o    = 32'(dist_i) >= OUT_W;
  assign stage[0] = data_i;

`ifdef ALIGN_STICKY_EN
  logic [SH_W-1:0] lost;
`endif

  generate
    for (genvar gi = 0; gi < SH_W; gi++) begin : g_stage
      localparam int S = 1 << gi;
      assign stage[gi+1] = amt[gi] ? aligned_t'($signed(stage[gi]) >>> S) : stage[gi];
`ifdef ALIGN_STICKY_EN
      // Bits falling off the bottom of this stage; the stages together cover all of them.
      localparam aligned_t MASK = (S >= OUT_W) ? {OUT_W{1'b1}} : aligned_t'((32'd1 << S) - 32'd1);
      assign lost[gi] = amt[gi] & (|(stage[gi] & MASK));
`endif
    end
  endgenerate

  assign data_o = stage[SH_W];

`ifdef ALIGN_STICKY_EN
  assign sticky_o = |lost;
`else
  assign sticky_o = 1'b0;
`endif

endmodule

// File: rtl/alignment.sv
// Exponent-alignment stage: registered arithmetic right shift by (exp_max - exp).
// Optional sticky jamming into bit 0 via ALIGN_STICKY_EN; ports identical in both builds.
module alignment
  import align_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  exp_t     exp,
  input  exp_t     exp_max,
  input  pp_t      signed_pp,
  output logic     out_valid,
  output aligned_t aligned_pp,
  output logic     exp_err
);

  logic [EXP_W:0] d_full;
  aligned_t       w;
  aligned_t       shifted;
  logic           sat;
  logic           sticky;
  aligned_t       result_d, result_q;
  logic           err_d, err_q;
  logic           valid_q;

  assign d_full = {1'b0, exp_max} - {1'b0, exp};
  assign w      = {signed_pp, {G{1'b0}}};

  align_barrel_shifter u_shifter (
    .data_i   (w),
    .dist_i   (d_full[EXP_W-1:0]),
    .data_o   (shifted),
    .sat_o    (sat),
    .sticky_o (sticky)
  );

  always_comb begin
    result_d = '0;
    err_d    = 1'b0;
    // A borrow out of the subtraction means exp > exp_max.
    if (d_full[EXP_W]) begin
      err_d = 1'b1;
    end else begin
      result_d    = sat ? {OUT_W{w[OUT_W-1]}} : shifted;
      result_d[0] = result_d[0] | sticky;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        err_q    <= err_d;
      end
    end
  end

  assign out_valid  = valid_q;
  assign aligned_pp = result_q;
  assign exp_err    = err_q;

endmodule

// File: tb/tb_alignment.sv
// Self-checking bench for alignment: directed literal vectors plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_alignment;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  exp;
  logic [4:0]  exp_max;
  logic [4:0]  signed_pp;
  logic        out_valid;
  logic [15:0] aligned_pp;
  logic        exp_err;

  int checks = 0;
  int failures = 0;

  alignment dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .exp        (exp),
    .exp_max    (exp_max),
    .signed_pp  (signed_pp),
    .out_valid  (out_valid),
    .aligned_pp (aligned_pp),
    .exp_err    (exp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: scale pp by 2^G, divide by 2^d with floor (arithmetic shift), saturate.
  function automatic void ref_align(input int e, input int m, input int p,
                                    output logic [15:0] v, output logic err);
    int d, wv, s;
    logic lost;
    if (e > m) begin
      v = 16'h0000;
      err = 1'b1;
    end else begin
      err = 1'b0;
      d = m - e;
      wv = p * 2048;
      if (d >= 16) begin
        s = (p < 0) ? -1 : 0;
        lost = (p != 0);
      end else begin
        s = wv >>> d;
        lost = ((s <<< d) != wv);
      end
      v = s[15:0];
`ifdef ALIGN_STICKY_EN
      v[0] = v[0] | lost;
`else
      if (lost) v = v;
`endif
    end
  endfunction

  // Model state: what the outputs must show after each edge.
  logic        m_valid;
  logic [15:0] m_val;
  logic        m_err;
  logic        m_ok = 1'b0;

  always @(posedge clk) begin
    logic [15:0] v;
    logic e;
    ref_align(int'(exp), int'(exp_max), int'($signed(signed_pp)), v, e);
    if (rst) begin
      m_valid <= 1'b0;
      m_val   <= 16'h0000;
      m_err   <= 1'b0;
      m_ok    <= 1'b1;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_val <= v;
        m_err <= e;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      check("cyc_aligned_pp", 32'(aligned_pp), 32'(m_val));
      check("cyc_exp_err", 32'(exp_err), 32'(m_err));
    end
  end

  typedef struct {
    string       name;
    logic [4:0]  e;
    logic [4:0]  m;
    logic [4:0]  p;
    logic [15:0] v;
    logic        err;
  } vec_t;

  vec_t vecs[8];

`ifdef ALIGN_STICKY_EN
  localparam logic [15:0] SAT_POS = 16'h0001;
`else
  localparam logic [15:0] SAT_POS = 16'h0000;
`endif

  task automatic apply(input vec_t t);
    in_valid  = 1'b1;
    exp       = t.e;
    exp_max   = t.m;
    signed_pp = t.p;
  endtask

  initial begin
    vecs[0] = '{"first_d3",  5'd2, 5'd5,  5'b11010, 16'hFA00, 1'b0};
    vecs[1] = '{"b2b_d1",    5'd4, 5'd5,  5'b11010, 16'hE800, 1'b0};
    vecs[2] = '{"b2b_d6",    5'd4, 5'd10, 5'b11010, 16'hFF40, 1'b0};
    vecs[3] = '{"b2b_pos",   5'd4, 5'd10, 5'b00111, 16'h00E0, 1'b0};
    vecs[4] = '{"sat_neg",   5'd0, 5'd31, 5'b11010, 16'hFFFF, 1'b0};
    vecs[5] = '{"sat_pos",   5'd0, 5'd31, 5'b00111, SAT_POS,  1'b0};
    vecs[6] = '{"exp_err",   5'd6, 5'd5,  5'b00111, 16'h0000, 1'b1};
    vecs[7] = '{"d_zero",    5'd5, 5'd5,  5'b00111, 16'h3800, 1'b0};

    rst = 1'b1;
    apply(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_aligned_pp", 32'(aligned_pp), 32'd0);
    check("rst_exp_err", 32'(exp_err), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check({vecs[k].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[k].name, "_pp"}, 32'(aligned_pp), 32'(vecs[k].v));
      check({vecs[k].name, "_err"}, 32'(exp_err), 32'(vecs[k].err));
      $display("beat %0d %s exp=%0d exp_max=%0d pp=%b -> aligned_pp=%h exp_err=%0d",
               k, vecs[k].name, vecs[k].e, vecs[k].m, vecs[k].p, aligned_pp, exp_err);
      if (k < 7) apply(vecs[k+1]);
      else begin
        in_valid  = 1'b0;
        exp       = 5'd0;
        exp_max   = 5'd31;
        signed_pp = 5'b10000;
      end
    end

    @(posedge clk);
    #1;
    check("hold_valid", 32'(out_valid), 32'd0);
    check("hold_pp", 32'(aligned_pp), 32'h3800);
    check("hold_err", 32'(exp_err), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst      = ($urandom_range(0, 63) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      exp_max  = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) exp = 5'($urandom_range(0, 31));
      else exp = 5'($urandom_range(0, int'(exp_max)));
      signed_pp = 5'($urandom_range(0, 31));
    end
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
